// File: rtl/datainput_loader.sv
// Stream-to-BRAM loader for DATAINPUT_TOP: writes BAND_WIDTH banks bank-major, then requests one burst.
// Optional RUN-state watchdog is built when DATAINPUT_LOADER_WDOG_EN is defined.
module datainput_loader #(
  parameter int SRAM_DEPTH  = 1024,
  parameter int BAND_WIDTH  = 25,
  parameter int DATA_WIDTH  = 8,
  parameter int GAP_CYCLES  = 3,
  parameter int WDOG_CYCLES = 65535,
  localparam int WW = $clog2(SRAM_DEPTH),
  localparam int BW = $clog2(BAND_WIDTH),
  localparam int AW = WW + BW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [10:0]           load_len_i,
  input  logic [10:0]           burst_size_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  output logic                  wea_o,
  output logic [AW-1:0]         addra_o,
  output logic [DATA_WIDTH-1:0] dia_o,
  output logic [10:0]           BURST_SIZE_o,
  output logic                  weight_ready_o,
  input  logic                  burst_last_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  localparam int LW = 11;
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam logic [1:0] S_RUN  = 2'd3;

  if (SRAM_DEPTH < 2 || SRAM_DEPTH > 1024 || BAND_WIDTH < 2 || WDOG_CYCLES < 1) begin : g_bad_cfg
    $error("datainput_loader: unsupported parameter set");
  end

  logic [1:0]    state;
  logic [WW-1:0] word;
  logic [BW-1:0] bank;
  logic [LW-1:0] len_q;
  logic [LW-1:0] burst_q;
  logic [GW-1:0] gap_cnt;
  logic          bl_q;

`ifdef DATAINPUT_LOADER_WDOG_EN
  localparam int DW = $clog2(WDOG_CYCLES + 1);
  logic [DW-1:0] wdog_cnt;
`endif

  logic accept;
  logic word_last;
  logic bank_last;
  logic cmd_bad;
  logic bl_rise;

  assign s_ready_o      = (state == S_LOAD);
  assign busy_o         = (state != S_IDLE);
  assign weight_ready_o = (state == S_RUN);
  assign BURST_SIZE_o   = (state == S_RUN) ? burst_q : '0;

  assign accept    = s_valid_i & s_ready_o;
  assign word_last = (LW'(word) == len_q - LW'(1));
  assign bank_last = (bank == BW'(BAND_WIDTH - 1));
  assign bl_rise   = burst_last_i & ~bl_q;
  assign cmd_bad   = (load_len_i == '0) || (load_len_i > LW'(SRAM_DEPTH)) ||
                     (burst_size_i == '0) || (burst_size_i > load_len_i);

  // NOTE: every register here uses <= so all updates see pre-edge values, regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      word    <= '0;
      bank    <= '0;
      len_q   <= '0;
      burst_q <= '0;
      gap_cnt <= '0;
      bl_q    <= 1'b0;
      wea_o   <= 1'b0;
      addra_o <= '0;
      dia_o   <= '0;
      done_o  <= 1'b0;
      err_o   <= 1'b0;
`ifdef DATAINPUT_LOADER_WDOG_EN
      wdog_cnt <= '0;
`endif
    end else begin
      bl_q   <= burst_last_i;
      wea_o  <= 1'b0;
      done_o <= 1'b0;
      err_o  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_i) begin
            len_q   <= load_len_i;
            burst_q <= burst_size_i;
            if (cmd_bad) begin
              err_o <= 1'b1;
            end else begin
              state <= S_LOAD;
              word  <= '0;
              bank  <= '0;
            end
          end
        end
        S_LOAD: begin
          // addra/dia only change on an accepted beat, so they hold between writes.
          if (accept) begin
            wea_o   <= 1'b1;
            addra_o <= {bank, word};
            dia_o   <= s_data_i;
            if (word_last) begin
              word <= '0;
              if (bank_last) begin
                state   <= S_GAP;
                gap_cnt <= '0;
              end else begin
                bank <= bank + BW'(1);
              end
            end else begin
              word <= word + WW'(1);
            end
          end
        end
        S_GAP: begin
          // The first GAP cycle carries the final write; GAP_CYCLES idle cycles follow it.
          if (gap_cnt == GW'(GAP_CYCLES)) begin
            state <= S_RUN;
`ifdef DATAINPUT_LOADER_WDOG_EN
            wdog_cnt <= '0;
`endif
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        S_RUN: begin
          if (bl_rise) begin
            state  <= S_IDLE;
            done_o <= 1'b1;
          end
`ifdef DATAINPUT_LOADER_WDOG_EN
          else if (wdog_cnt == DW'(WDOG_CYCLES - 1)) begin
            state <= S_IDLE;
            err_o <= 1'b1;
          end else begin
            wdog_cnt <= wdog_cnt + DW'(1);
          end
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_datainput_loader.sv
// Self-checking bench for datainput_loader: a write-queue model derived from beat index and load length,
// checked every cycle, plus directed command/handshake scenarios with literal expectations.
module tb_datainput_loader;

  localparam int DEPTH = 1024;
  localparam int BANKS = 25;
  localparam int GAP   = 3;
`ifdef DATAINPUT_LOADER_WDOG_EN
  localparam int TB_WDOG = 100;
`else
  localparam int TB_WDOG = 65535;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_i = 1'b0;
  logic [10:0] load_len_i = '0;
  logic [10:0] burst_size_i = '0;
  logic        s_valid_i = 1'b0;
  logic        s_ready_o;
  logic [7:0]  s_data_i = '0;
  logic        wea_o;
  logic [14:0] addra_o;
  logic [7:0]  dia_o;
  logic [10:0] BURST_SIZE_o;
  logic        weight_ready_o;
  logic        burst_last_i = 1'b0;
  logic        busy_o;
  logic        done_o;
  logic        err_o;

  datainput_loader #(
    .SRAM_DEPTH (DEPTH),
    .BAND_WIDTH (BANKS),
    .DATA_WIDTH (8),
    .GAP_CYCLES (GAP),
    .WDOG_CYCLES(TB_WDOG)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start_i),
    .load_len_i    (load_len_i),
    .burst_size_i  (burst_size_i),
    .s_valid_i     (s_valid_i),
    .s_ready_o     (s_ready_o),
    .s_data_i      (s_data_i),
    .wea_o         (wea_o),
    .addra_o       (addra_o),
    .dia_o         (dia_o),
    .BURST_SIZE_o  (BURST_SIZE_o),
    .weight_ready_o(weight_ready_o),
    .burst_last_i  (burst_last_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .err_o         (err_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          at;
    logic [14:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t         expq[$];
  bit          mon_en = 1'b0;
  int          wr_count = 0;
  int          cap_idx = -1;
  logic [14:0] cap_addr = '0;
  logic [14:0] last_addr = '0;
  logic [7:0]  last_data = '0;
  int          model_last_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Beat n of a load lands in bank n/len at word n%len.
  function automatic logic [14:0] addr_of(input int n, input int len);
    return 15'(((n / len) << 10) | (n % len));
  endfunction

  // Each cycle the write port must match the model: a write exactly one cycle after each accepted beat.
  bit exp_wea;
  always @(negedge clk) begin
    if (mon_en) begin
      exp_wea = (expq.size() > 0) && (expq[0].at == cyc);
      check("wea", wea_o, exp_wea);
      if (exp_wea) begin
        check("addra", addra_o, expq[0].addr);
        check("dia", dia_o, expq[0].data);
        if (wr_count == cap_idx) cap_addr = addra_o;
        last_addr = addra_o;
        last_data = dia_o;
        wr_count++;
        void'(expq.pop_front());
      end
    end
  end

  task automatic cmd(input int len, input int bs);
    @(negedge clk);
    load_len_i   = 11'(len);
    burst_size_i = 11'(bs);
    start_i      = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic drive(input int len, input int nbeats, input bit rnd, input int salt);
    int n = 0;
    int budget = 4 * nbeats + 100;
    bit v;
    while (n < nbeats) begin
      @(negedge clk);
      v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      s_valid_i = v;
      s_data_i  = 8'(n + salt);
      if (v && s_ready_o) begin
        expq.push_back('{cyc + 1, addr_of(n, len), 8'(n + salt)});
        model_last_cyc = cyc + 1;
        n++;
      end
      budget--;
      if (budget == 0) begin
        check("drive_timeout_beats", n, nbeats);
        break;
      end
    end
    @(negedge clk);
    s_valid_i = 1'b0;
  endtask

  task automatic wait_ready(input string name, output int at);
    at = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (weight_ready_o) begin
        at = cyc;
        break;
      end
    end
    check({name, "_ready_cycle"}, at, model_last_cyc + GAP + 1);
  endtask

  task automatic finish_burst(input string name);
    @(negedge clk);
    burst_last_i = 1'b1;
    @(negedge clk);
    check({name, "_done"}, done_o, 1'b1);
    check({name, "_wr_low"}, weight_ready_o, 1'b0);
    check({name, "_idle"}, busy_o, 1'b0);
    check({name, "_bs_cleared"}, BURST_SIZE_o, 11'd0);
    @(negedge clk);
    check({name, "_done_pulse"}, done_o, 1'b0);
    burst_last_i = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_wea"}, wea_o, 1'b0);
    check({name, "_addra"}, addra_o, 15'd0);
    check({name, "_dia"}, dia_o, 8'd0);
    check({name, "_ready"}, s_ready_o, 1'b0);
    check({name, "_wr"}, weight_ready_o, 1'b0);
    check({name, "_bs"}, BURST_SIZE_o, 11'd0);
    check({name, "_busy"}, busy_o, 1'b0);
    check({name, "_done"}, done_o, 1'b0);
    check({name, "_err"}, err_o, 1'b0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: got cycle %0d want finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int at;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;
    mon_en = 1'b1;

    // 1: full load, data = beat index, so dia equals addra[7:0].
    cmd(1024, 1024);
    check("t1_busy", busy_o, 1'b1);
    check("t1_s_ready", s_ready_o, 1'b1);
    wr_count = 0;
    cap_idx  = 1024;
    drive(1024, 25600, 1'b0, 0);
    check("t1_ready_drop", s_ready_o, 1'b0);
    wait_ready("t1", at);
    check("t1_count", wr_count, 25600);
    check("t1_last_addr", last_addr, 15'h63FF);
    check("t1_last_data", last_data, 8'hFF);
    check("t1_bank1_addr", cap_addr, 15'h0400);
    check("t1_bs", BURST_SIZE_o, 11'd1024);
    finish_burst("t1");

    // 2: load_len 784; burst_last already high when RUN starts must not count.
    cmd(784, 196);
    wr_count = 0;
    cap_idx  = 784;
    drive(784, 19600, 1'b0, 0);
    burst_last_i = 1'b1;
    wait_ready("t2", at);
    check("t2_count", wr_count, 19600);
    check("t2_bank1_addr", cap_addr, 15'h0400);
    check("t2_last_addr", last_addr, 15'h630F);
    check("t2_last_data", last_data, 8'h8F);
    for (int i = 0; i < 5; i++) begin
      check("t2_bs_hold", BURST_SIZE_o, 11'd196);
      check("t2_no_done", done_o, 1'b0);
      check("t2_wr_hold", weight_ready_o, 1'b1);
      @(negedge clk);
    end
    burst_last_i = 1'b0;
    finish_burst("t2");

    // 3: random 50% valid; model only expects writes for accepted beats.
    cmd(64, 64);
    wr_count = 0;
    cap_idx  = -1;
    drive(64, 1600, 1'b1, 17);
    wait_ready("t3", at);
    check("t3_count", wr_count, 1600);
    check("t3_last_addr", last_addr, 15'h603F);
    check("t3_last_data", last_data, 8'h50);
    finish_burst("t3");

    // 4: bad commands.
    cmd(0, 1);
    check("t4a_err", err_o, 1'b1);
    check("t4a_busy", busy_o, 1'b0);
    @(negedge clk);
    check("t4a_err_pulse", err_o, 1'b0);
    cmd(25, 30);
    check("t4b_err", err_o, 1'b1);
    check("t4b_busy", busy_o, 1'b0);
    cmd(1025, 1);
    check("t4c_err", err_o, 1'b1);
    check("t4c_busy", busy_o, 1'b0);
    cmd(25, 25);
    check("t4d_no_err", err_o, 1'b0);
    check("t4d_busy", busy_o, 1'b1);
    #2 rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // 5: reset mid-load at beat 500, then a fresh short load.
    cmd(1024, 1024);
    wr_count = 0;
    drive(1024, 500, 1'b0, 0);
    #2 rst = 1'b0;
    expq.delete();
    #1 check_all_zero("t5_in_reset");
    @(negedge clk);
    check_all_zero("t5_in_reset2");
    check("t5_partial_count", wr_count, 500);
    rst = 1'b1;
    cmd(25, 25);
    wr_count = 0;
    cap_idx  = 0;
    drive(25, 625, 1'b0, 3);
    wait_ready("t5", at);
    check("t5_first_addr", cap_addr, 15'h0000);
    check("t5_count", wr_count, 625);
    check("t5_last_addr", last_addr, 15'h6018);
    load_len_i = 11'd0;
    start_i    = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    check("t5_start_ignored_err", err_o, 1'b0);
    check("t5_start_ignored_busy", busy_o, 1'b1);
    check("t5_start_ignored_wr", weight_ready_o, 1'b1);
    check("t5_start_ignored_bs", BURST_SIZE_o, 11'd25);
    finish_burst("t5");

    // 6: RUN with burst_last held low.
    cmd(1, 1);
    wr_count = 0;
    drive(1, 25, 1'b0, 0);
    wait_ready("t6", at);
    check("t6_last_addr", last_addr, 15'h6000);
`ifdef DATAINPUT_LOADER_WDOG_EN
    begin
      int err_at = -1;
      for (int i = 0; i < 200; i++) begin
        if (err_o) begin
          err_at = cyc;
          break;
        end
        @(negedge clk);
      end
      check("t6_wdog_cycle", err_at, at + TB_WDOG);
      check("t6_wdog_wr", weight_ready_o, 1'b0);
      check("t6_wdog_busy", busy_o, 1'b0);
      check("t6_wdog_done", done_o, 1'b0);
      @(negedge clk);
      check("t6_wdog_err_pulse", err_o, 1'b0);
    end
`else
    repeat (300) begin
      @(negedge clk);
      if (err_o || !weight_ready_o) break;
    end
    check("t6_wait_err", err_o, 1'b0);
    check("t6_wait_wr", weight_ready_o, 1'b1);
    finish_burst("t6");
`endif

    check("end_queue_empty", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
